// File: rtl/motor_move_sequencer.sv
// Trapezoidal move sequencer: ramps PWM duty up, cruises, ramps down
// while counting encoder edges toward a commanded relative distance.
module motor_move_sequencer #(
  parameter logic [7:0]  DUTY_MIN    = 8'd40,
  parameter logic [7:0]  DUTY_MAX    = 8'd255,
  parameter logic [15:0] RAMP_DIV    = 16'd1000,
  parameter logic [31:0] DECEL_CNT   = 32'd200,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [31:0] cmd_counts,
  input  logic        abort,
  input  logic        fault_clr,
  input  logic        enc_edge,
  output logic        motor_en,
  output logic        motor_dir,
  output logic [7:0]  duty,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] remaining
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEL  = 3'd1;
  localparam logic [2:0] S_CRUISE = 3'd2;
  localparam logic [2:0] S_DECEL  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  logic [2:0]  r_state;
  logic        r_cmd_ready;
  logic        r_motor_en;
  logic        r_motor_dir;
  logic [7:0]  r_duty;
  logic        r_busy;
  logic        r_done;
  logic        r_fault;
  logic [31:0] r_remaining;
  logic [15:0] r_ramp;
  logic [31:0] r_stall;

  logic [31:0] w_rem_dec;
  logic        w_complete;
  logic        w_timeout;
  logic        w_step;
  logic        w_near;

  assign w_rem_dec  = (enc_edge && (r_remaining != 32'd0))
                    ? r_remaining - 32'd1 : r_remaining;
  assign w_complete = (enc_edge && (r_remaining == 32'd1))
                    || (r_remaining == 32'd0);
  assign w_timeout  = !enc_edge && (r_stall == TIMEOUT_CYC - 32'd1);
  assign w_step     = (r_ramp == RAMP_DIV - 16'd1);
  assign w_near     = (r_remaining <= DECEL_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_motor_en  <= 1'b0;
      r_motor_dir <= 1'b0;
      r_duty      <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_remaining <= 32'd0;
      r_ramp      <= 16'd0;
      r_stall     <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_motor_dir <= cmd_dir;
            r_remaining <= cmd_counts;
            r_cmd_ready <= 1'b0;
            r_ramp      <= 16'd0;
            r_stall     <= 32'd0;
            if (cmd_counts == 32'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_ACCEL;
              r_motor_en <= 1'b1;
              r_duty     <= DUTY_MIN;
              r_busy     <= 1'b1;
            end
          end
        end
        S_ACCEL, S_CRUISE, S_DECEL: begin
          r_remaining <= w_rem_dec;
          r_stall     <= enc_edge ? 32'd0 : r_stall + 32'd1;
          // completion and abort share the exit; abort leaves remaining nonzero
          if (w_complete || abort) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_motor_en <= 1'b0;
            r_duty     <= 8'd0;
            r_busy     <= 1'b0;
          end else if (w_timeout) begin
            r_state    <= S_FAULT;
            r_fault    <= 1'b1;
            r_motor_en <= 1'b0;
            r_duty     <= 8'd0;
            r_busy     <= 1'b0;
          end else begin
            r_ramp <= w_step ? 16'd0 : r_ramp + 16'd1;
            if ((r_state != S_DECEL) && w_near) begin
              r_state <= S_DECEL;
              r_ramp  <= 16'd0;
            end else if ((r_state == S_ACCEL)
                         && (r_duty == DUTY_MAX)) begin
              r_state <= S_CRUISE;
              r_ramp  <= 16'd0;
            end else if (w_step) begin
              if ((r_state == S_ACCEL) && (r_duty < DUTY_MAX))
                r_duty <= r_duty + 8'd1;
              else if ((r_state == S_DECEL) && (r_duty > DUTY_MIN))
                r_duty <= r_duty - 8'd1;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
        S_FAULT: begin
          if (fault_clr) begin
            r_state     <= S_IDLE;
            r_fault     <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_motor_en  <= 1'b0;
          r_duty      <= 8'd0;
          r_busy      <= 1'b0;
          r_fault     <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign motor_en  = r_motor_en;
  assign motor_dir = r_motor_dir;
  assign duty      = r_duty;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fault     = r_fault;
  assign remaining = r_remaining;

endmodule

// File: tb/tb_motor_move_sequencer.sv
// Scoreboard bench for motor_move_sequencer: stimulus pushes expected
// move-end events, a negedge monitor pops them on done/fault.
module tb_motor_move_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [31:0] cmd_counts = 32'd0;
  logic        abort = 1'b0;
  logic        fault_clr = 1'b0;
  logic        enc_edge = 1'b0;
  logic        motor_en;
  logic        motor_dir;
  logic [7:0]  duty;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] remaining;

  always #5 clk = ~clk;

  motor_move_sequencer #(
    .DUTY_MIN   (8'd40),
    .DUTY_MAX   (8'd255),
    .RAMP_DIV   (16'd4),
    .DECEL_CNT  (32'd200),
    .TIMEOUT_CYC(32'd64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_counts(cmd_counts),
    .abort     (abort),
    .fault_clr (fault_clr),
    .enc_edge  (enc_edge),
    .motor_en  (motor_en),
    .motor_dir (motor_dir),
    .duty      (duty),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .remaining (remaining)
  );

  typedef struct {
    bit          is_fault;
    logic [31:0] rem;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t0 = 0;
  logic fault_q = 1'b0;
  logic [7:0] max_duty;
  bit   en_seen;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (done || (fault && !fault_q))) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got done=%0d fault=%0d required none",
                 done, fault);
      end else begin
        e = sb.pop_front();
        chk("evt_kind", 32'(fault), 32'(e.is_fault));
        chk("evt_rem", remaining, e.rem);
        chk("evt_lat", 32'(cyc - t0), 32'(e.lat));
        chk("evt_en", 32'(motor_en), 32'd0);
        chk("evt_duty", 32'(duty), 32'd0);
        chk("evt_busy", 32'(busy), 32'd0);
      end
    end
    fault_q = fault;
  end

  task automatic issue(input logic dir, input logic [31:0] cnt,
                       input bit push, input bit ef,
                       input logic [31:0] er, input int el);
    exp_t e;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_counts = cnt;
    t0 = cyc + 1;
    if (push) begin
      e.is_fault = ef;
      e.rem = er;
      e.lat = el;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required end within limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_en", 32'(motor_en), 32'd0);
    chk("rst_duty", 32'(duty), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_rem", remaining, 32'd0);
    chk("rst_dir", 32'(motor_dir), 32'd0);
    rst_n = 1'b1;

    // full trapezoid: 1000 edges, one every 8 clocks
    issue(1'b1, 32'd1000, 1'b1, 1'b0, 32'd0, 8000);
    max_duty = 8'd0;
    for (int c = 0; c < 8003; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (duty > max_duty) max_duty = duty;
      case (c)
        0: begin
          chk("m_en_c0", 32'(motor_en), 32'd1);
          chk("m_duty_c0", 32'(duty), 32'd40);
          chk("m_busy_c0", 32'(busy), 32'd1);
          chk("m_rdy_c0", 32'(cmd_ready), 32'd0);
          chk("m_dir_c0", 32'(motor_dir), 32'd1);
          chk("m_rem_c0", remaining, 32'd1000);
        end
        3:    chk("m_duty_c3", 32'(duty), 32'd40);
        4:    chk("m_duty_c4", 32'(duty), 32'd41);
        859:  chk("m_duty_c859", 32'(duty), 32'd254);
        860:  chk("m_duty_c860", 32'(duty), 32'd255);
        2000: chk("m_cruise", 32'(duty), 32'd255);
        6400: chk("m_rem_200", remaining, 32'd200);
        6404: chk("m_duty_c6404", 32'(duty), 32'd255);
        6405: chk("m_duty_c6405", 32'(duty), 32'd254);
        7999: begin
          chk("m_floor", 32'(duty), 32'd40);
          chk("m_busy_end", 32'(busy), 32'd1);
          chk("m_rem_1", remaining, 32'd1);
        end
        8001: chk("m_rdy_after", 32'(cmd_ready), 32'd1);
        default: ;
      endcase
      enc_edge = ((c % 8) == 7) && (((c + 1) / 8) <= 1000);
    end
    chk("m_max_duty", 32'(max_duty), 32'd255);

    // zero-length move
    issue(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 0);
    en_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (motor_en) en_seen = 1'b1;
      if (c == 0) chk("z_done", 32'(done), 32'd1);
      if (c == 1) chk("z_ready", 32'(cmd_ready), 32'd1);
    end
    chk("z_en_never", 32'(en_seen), 32'd0);

    // short move: straight to DECEL, duty pinned at floor
    issue(1'b1, 32'd100, 1'b1, 1'b0, 32'd0, 800);
    max_duty = 8'd0;
    for (int c = 0; c < 802; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (busy && duty > max_duty) max_duty = duty;
      if (c == 4) chk("s_duty_c4", 32'(duty), 32'd40);
      if (c == 799) chk("s_rem_1", remaining, 32'd1);
      enc_edge = ((c % 8) == 7) && (((c + 1) / 8) <= 100);
    end
    chk("s_max_duty", 32'(max_duty), 32'd40);

    // abort after 300 edges
    issue(1'b0, 32'd1000, 1'b1, 1'b0, 32'd700, 2404);
    for (int c = 0; c < 2406; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c == 2403) begin
        chk("a_en", 32'(motor_en), 32'd1);
        chk("a_rem", remaining, 32'd700);
      end
      if (c == 2405) begin
        chk("a_ready", 32'(cmd_ready), 32'd1);
        chk("a_rem_kept", remaining, 32'd700);
      end
      enc_edge = ((c % 8) == 7) && (((c + 1) / 8) <= 300);
      abort = (c == 2403);
    end
    abort = 1'b0;

    // stall timeout, commands ignored while faulted
    issue(1'b1, 32'd50, 1'b1, 1'b1, 32'd50, 64);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      cmd_valid = (c >= 66) && (c < 70);
      cmd_counts = 32'd5;
      if (c == 63) chk("f_not_yet", 32'(fault), 32'd0);
      if (c == 64) chk("f_ready", 32'(cmd_ready), 32'd0);
      if (c == 70) begin
        chk("f_rem_frozen", remaining, 32'd50);
        chk("f_held", 32'(fault), 32'd1);
        chk("f_ready_held", 32'(cmd_ready), 32'd0);
      end
      if (c == 71) begin
        chk("f_clr_ready", 32'(cmd_ready), 32'd1);
        chk("f_clr_fault", 32'(fault), 32'd0);
      end
      fault_clr = (c == 70);
    end

    // last edge, abort and timeout in the same cycle
    issue(1'b1, 32'd1, 1'b1, 1'b0, 32'd0, 64);
    for (int c = 0; c < 67; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c == 64) chk("p_fault", 32'(fault), 32'd0);
      if (c == 65) chk("p_ready", 32'(cmd_ready), 32'd1);
      enc_edge = (c == 63);
      abort = (c == 63);
    end

    // reset in the middle of a move
    issue(1'b1, 32'd1000, 1'b0, 1'b0, 32'd0, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c == 11) begin
        chk("r_en", 32'(motor_en), 32'd0);
        chk("r_duty", 32'(duty), 32'd0);
        chk("r_ready", 32'(cmd_ready), 32'd1);
        chk("r_rem", remaining, 32'd0);
      end
      if (c == 19) chk("r_idle", 32'(busy), 32'd0);
      rst_n = !(c == 10);
      enc_edge = ((c % 8) == 7);
    end
    enc_edge = 1'b0;

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
